layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_scheduler.sv | 144 ++++++++++++++
 tb/tb_layer_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// Layer scheduler: walks N_NEURONS neurons through one shared Neuron datapath,
// spending three cycles on each (fetch, load, write), then pulses done.
module layer_scheduler #(
  parameter int N_NEURONS = 30,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [495:0]  in_vec,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [495:0]  mem_weight,
  input  logic [7:0]    mem_bias,
  output logic [495:0]  nrn_in,
  output logic [495:0]  nrn_weight,
  output logic [7:0]    nrn_bias,
  input  logic [7:0]    nrn_out,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_k;
  logic [AW-1:0] w_k_next;
  logic          w_last;
  logic          w_accept;
  logic          w_we;

  logic          r_mem_rd_en;
  logic [AW-1:0] r_mem_addr;
  logic          r_out_we;
  logic [AW-1:0] r_out_addr;
  logic [7:0]    r_out_data;
  logic          r_busy;
  logic          r_done;
  logic [495:0]  r_nrn_in;
  logic [495:0]  r_nrn_weight;
  logic [7:0]    r_nrn_bias;

  assign w_last   = (r_k == AW'(N_NEURONS - 1));
  assign w_accept = (r_state == S_IDLE) && start;
  // The Neuron result is combinational on the nrn_* registers, so the write
  // data must pass straight through in WRITE; an aborted write is masked.
  assign w_we     = r_out_we & ~abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
      S_FETCH: w_next = abort ? S_IDLE : S_LOAD;
      S_LOAD:  w_next = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Neuron index for the next cycle; never advances past the last neuron.
  always_comb begin
    w_k_next = r_k;
    if (w_accept) begin
      w_k_next = '0;
    end else if ((r_state == S_WRITE) && !abort && !w_last) begin
      w_k_next = r_k + AW'(1);
    end else begin
      w_k_next = r_k;
    end
  end

  // Output and datapath registers, loaded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_out_we     <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_nrn_in     <= '0;
      r_nrn_weight <= '0;
      r_nrn_bias   <= 8'd0;
    end else begin
      r_k         <= w_k_next;
      r_mem_rd_en <= (w_next == S_FETCH);
      r_out_we    <= (w_next == S_WRITE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      if (w_next == S_FETCH) r_mem_addr <= w_k_next;
      if (w_next == S_WRITE) r_out_addr <= r_k;
      if (w_we) r_out_data <= nrn_out;
      if (w_accept) r_nrn_in <= in_vec;
      if (r_state == S_LOAD) begin
        r_nrn_weight <= mem_weight;
        r_nrn_bias   <= mem_bias;
      end
    end
  end

  assign mem_rd_en  = r_mem_rd_en;
  assign mem_addr   = r_mem_addr;
  assign out_we     = w_we;
  assign out_addr   = r_out_addr;
  assign out_data   = w_we ? nrn_out : r_out_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign nrn_in     = r_nrn_in;
  assign nrn_weight = r_nrn_weight;
  assign nrn_bias   = r_nrn_bias;

endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized bench for layer_scheduler with a 1-cycle weight memory and a
// stand-in Neuron; expected timing and data come from per-cycle pass arithmetic.
module tb_layer_scheduler;

  localparam int N  = 3;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [495:0]  in_vec = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [495:0]  mem_weight = '0;
  logic [7:0]    mem_bias = 8'd0;
  logic [495:0]  nrn_in;
  logic [495:0]  nrn_weight;
  logic [7:0]    nrn_bias;
  logic [7:0]    nrn_out;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          busy;
  logic          done;

  logic [495:0] wmem [64];
  logic [7:0]   bmem [64];

  int n_tests = 0;
  int n_fail  = 0;
  int hold_maddr = 0;
  int hold_oaddr = 0;
  int hold_odata = 0;

  layer_scheduler #(.N_NEURONS(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_vec(in_vec),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_weight(mem_weight),
    .mem_bias(mem_bias), .nrn_in(nrn_in), .nrn_weight(nrn_weight),
    .nrn_bias(nrn_bias), .nrn_out(nrn_out), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nfun(input logic [495:0] a, input logic [495:0] w,
                                      input logic [7:0] b);
    logic [31:0] s;
    s = 32'(b);
    for (int i = 0; i < 62; i++) s = s + 32'(a[i*8 +: 8] ^ w[i*8 +: 8]);
    return {1'b0, s[6:0]};
  endfunction

  function automatic logic [495:0] rand496();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom();
    return t[495:0];
  endfunction

  // Stand-in Neuron and single-cycle-latency weight memory.
  always_comb nrn_out = nfun(nrn_in, nrn_weight, nrn_bias);

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_weight <= wmem[mem_addr];
      mem_bias   <= bmem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) begin
      wmem[i] = rand496();
      bmem[i] = 8'($urandom());
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_we"},   64'(out_we), 64'd0);
    check({tag, "_rd"},   64'(mem_rd_en), 64'd0);
    check({tag, "_maddr"}, 64'(mem_addr), 64'(hold_maddr));
    check({tag, "_oaddr"}, 64'(out_addr), 64'(hold_oaddr));
    check({tag, "_odata"}, 64'(out_data), 64'(hold_odata));
  endtask

  // One pass from IDLE; ab_c>0 raises abort during cycle ab_c after the start edge.
  task automatic run_pass(input int ab_c, input bit chg);
    logic [495:0] vec;
    int k;
    bit ab;
    bit exp_rd;
    bit exp_we;
    vec = rand496();
    in_vec = vec;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 3*N+1; c++) begin
      ab = (c == ab_c);
      abort = ab;
      if (chg) in_vec = rand496();
      if (c % 5 == 2) start = 1'b1;
      k = (c - 1) / 3;
      @(negedge clk);
      exp_rd = (c % 3 == 1) && (c < 3*N+1);
      exp_we = (c % 3 == 0) && !ab;
      if (exp_rd) hold_maddr = k;
      if (c % 3 == 0) hold_oaddr = k;
      if (exp_we) hold_odata = int'(nfun(vec, wmem[k], bmem[k]));
      check("rd",    64'(mem_rd_en), 64'(exp_rd));
      check("maddr", 64'(mem_addr), 64'(hold_maddr));
      check("we",    64'(out_we), 64'(exp_we));
      check("oaddr", 64'(out_addr), 64'(hold_oaddr));
      check("odata", 64'(out_data), 64'(hold_odata));
      check("busy",  64'(busy), 64'd1);
      check("done",  64'(done), 64'(c == 3*N+1));
      check("nrn_in", 64'(nrn_in == vec), 64'd1);
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      if (ab) break;
    end
    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    fill_mem();
    #2;
    check_idle("rst");
    check("rst_nrn_in", 64'(nrn_in == '0), 64'd1);
    check("rst_bias", 64'(nrn_bias), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_pass(0, 1'b0);
    run_pass(0, 1'b1);
    run_pass(6, 1'b0);
    run_pass(0, 1'b0);
    run_pass(4, 1'b0);
    run_pass(2, 1'b1);
    run_pass(9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      fill_mem();
      run_pass(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3*N)), 1'b1);
    end

    // Asynchronous reset during LOAD of neuron 1.
    in_vec = rand496();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    hold_maddr = 0;
    hold_oaddr = 0;
    hold_odata = 0;
    check_idle("arst");
    check("arst_nrn_in", 64'(nrn_in == '0), 64'd1);
    check("arst_weight", 64'(nrn_weight == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("after_rst");
    end
    @(posedge clk);
    #1;
    run_pass(0, 1'b0);

    // Start held high: two back-to-back passes, the second accepted from IDLE.
    begin
      logic [495:0] vec;
      int p;
      int k;
      bit inpass;
      bit exp_we;
      vec = rand496();
      in_vec = vec;
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
        @(negedge clk);
        p = (c <= 11) ? c : c - 11;
        inpass = (p >= 1) && (p <= 3*N+1);
        exp_we = inpass && (p % 3 == 0) && (p <= 3*N);
        k = p / 3 - 1;
        check("hold_we",   64'(out_we), 64'(exp_we));
        check("hold_done", 64'(done), 64'(p == 3*N+1));
        check("hold_busy", 64'(busy), 64'(inpass));
        if (exp_we) begin
          hold_oaddr = k;
          hold_odata = int'(nfun(vec, wmem[k], bmem[k]));
          check("hold_oaddr", 64'(out_addr), 64'(hold_oaddr));
          check("hold_odata", 64'(out_data), 64'(hold_odata));
        end
        if (c == 12) start = 1'b0;
      end
      hold_maddr = N - 1;
      @(posedge clk);
      #1;
    end

    run_pass(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
